// File: rtl/key_schedule_ctrl.sv
// Key schedule sequencer: holds NUM_KEYS key slots and presents one per
// epoch of EPOCH_LEN cycles, cycling through all slots once per period.
module key_schedule_ctrl #(
  parameter int unsigned KEY_W     = 16,
  parameter int unsigned NUM_KEYS  = 5,
  parameter int unsigned EPOCH_LEN = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [KEY_W-1:0] cfg_wdata,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic [2:0]       epoch_idx,
  output logic             sync_pulse,
  output logic             busy,
  output logic             err
);

  localparam int unsigned PERIOD = NUM_KEYS * EPOCH_LEN;
  localparam int unsigned CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned PW     = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [PW-1:0]       phase;
  logic [NUM_KEYS-1:0] mask;
  logic [KEY_W-1:0]    slot [NUM_KEYS];
  logic                addr_ok;
  logic                all_written;

  assign addr_ok     = ({29'd0, cfg_addr} < NUM_KEYS);
  assign all_written = &mask;

  // phase tracks position inside the epoch so epoch_idx advances without a divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      phase     <= '0;
      epoch_idx <= '0;
      mask      <= '0;
      err       <= 1'b0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) slot[i] <= '0;
    end else begin
      if (cfg_we) begin
        if (state == IDLE && addr_ok) begin
          slot[cfg_addr] <= cfg_wdata;
          mask[cfg_addr] <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start && !stop) begin
            if (all_written) begin
              state     <= RUN;
              cnt       <= '0;
              phase     <= '0;
              epoch_idx <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state     <= IDLE;
            cnt       <= '0;
            phase     <= '0;
            epoch_idx <= '0;
          end else if (pause) begin
            state <= PAUSED;
          end else if (cnt == CW'(PERIOD - 1)) begin
            cnt       <= '0;
            phase     <= '0;
            epoch_idx <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (phase == PW'(EPOCH_LEN - 1)) begin
              phase     <= '0;
              epoch_idx <= epoch_idx + 3'd1;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        PAUSED: begin
          if (stop) begin
            state     <= IDLE;
            cnt       <= '0;
            phase     <= '0;
            epoch_idx <= '0;
          end else if (!pause) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // decoded straight from registered state so rst drops them without a clock edge
  always_comb begin
    busy       = (state != IDLE);
    key_valid  = busy;
    key_out    = busy ? slot[epoch_idx] : '0;
    sync_pulse = (state == RUN) && (cnt == '0);
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: directed scenarios plus random stimulus, all
// checked every cycle against a period-counter reference model.
module tb_key_schedule_ctrl;

  localparam int KEY_W     = 16;
  localparam int NUM_KEYS  = 5;
  localparam int EPOCH_LEN = 13;
  localparam int PERIOD    = NUM_KEYS * EPOCH_LEN;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_we = 1'b0;
  logic [2:0]       cfg_addr = '0;
  logic [KEY_W-1:0] cfg_wdata = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             pause = 1'b0;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic [2:0]       epoch_idx;
  logic             sync_pulse;
  logic             busy;
  logic             err;

  key_schedule_ctrl #(.KEY_W(KEY_W), .NUM_KEYS(NUM_KEYS), .EPOCH_LEN(EPOCH_LEN)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .stop(stop), .pause(pause), .key_out(key_out), .key_valid(key_valid),
    .epoch_idx(epoch_idx), .sync_pulse(sync_pulse), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: sequencing as a plain period count, epoch by division
  int m_slot [NUM_KEYS];
  bit m_mask [NUM_KEYS];
  bit m_run, m_paused, m_err;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_KEYS; i++) begin
      m_slot[i] = 0;
      m_mask[i] = 1'b0;
    end
    m_run = 1'b0; m_paused = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit full;
    full = 1'b1;
    for (int i = 0; i < NUM_KEYS; i++) full &= m_mask[i];
    if (cfg_we) begin
      if (!m_run && int'(cfg_addr) < NUM_KEYS) begin
        m_slot[cfg_addr] = int'(cfg_wdata);
        m_mask[cfg_addr] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (!m_run) begin
      if (start && !stop) begin
        if (full) begin m_run = 1'b1; m_paused = 1'b0; m_cnt = 0; end
        else m_err = 1'b1;
      end
    end else if (stop) begin
      m_run = 1'b0; m_paused = 1'b0; m_cnt = 0;
    end else if (m_paused) begin
      if (!pause) m_paused = 1'b0;
    end else if (pause) begin
      m_paused = 1'b1;
    end else begin
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  endtask

  task automatic compare();
    check("busy", 32'(busy), 32'(m_run));
    check("key_valid", 32'(key_valid), 32'(m_run));
    check("key_out", 32'(key_out), m_run ? m_slot[m_cnt / EPOCH_LEN] : 0);
    check("epoch_idx", 32'(epoch_idx), m_cnt / EPOCH_LEN);
    check("sync_pulse", 32'(sync_pulse), 32'(m_run && !m_paused && m_cnt == 0));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input bit we, input int addr, input int wd,
                       input bit st, input bit sp, input bit pa);
    cfg_we = we; cfg_addr = 3'(addr); cfg_wdata = KEY_W'(wd);
    start = st; stop = sp; pause = pa;
    cyc();
    cfg_we = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  // pulse rst mid-cycle and confirm outputs drop before any clock edge
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_key", 32'(key_out), 32'd0);
    check("rst_sync", 32'(sync_pulse), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    compare();
  endtask

  int keys [NUM_KEYS] = '{16'hFCD6, 16'h63DC, 16'h0236, 16'hD940, 16'h94B6};

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(negedge clk);
    async_reset();

    // full schedule across one wrap
    for (int i = 0; i < NUM_KEYS; i++) drive(1, i, keys[i], 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    check("first_key", 32'(key_out), 32'hFCD6);
    check("first_sync", 32'(sync_pulse), 32'd1);
    idle(PERIOD + 3);
    drive(0, 0, 0, 0, 1, 0);

    // incomplete mask: start refused
    async_reset();
    for (int i = 0; i < NUM_KEYS - 1; i++) drive(1, i, keys[i], 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    check("partial_valid", 32'(key_valid), 32'd0);
    check("partial_err", 32'(err), 32'd1);

    // write coinciding with start sees the pre-write mask
    async_reset();
    for (int i = 0; i < NUM_KEYS - 1; i++) drive(1, i, keys[i], 0, 0, 0);
    drive(1, NUM_KEYS - 1, keys[NUM_KEYS - 1], 1, 0, 0);
    check("coincide_busy", 32'(busy), 32'd0);

    // fresh run: pause at counter 12, write while running, stop+pause+start at 30
    async_reset();
    for (int i = 0; i < NUM_KEYS; i++) drive(1, i, keys[i], 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    idle(12);
    for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 0, 1);
    check("paused_key", 32'(key_out), 32'hFCD6);
    idle(2);
    check("resume_key", 32'(key_out), 32'h63DC);
    drive(1, 2, 16'h1234, 0, 0, 0);
    idle(16);
    drive(0, 0, 0, 1, 1, 1);
    check("stop_key", 32'(key_out), 32'd0);
    idle(2);
    drive(0, 0, 0, 1, 0, 0);
    check("restart_key", 32'(key_out), 32'hFCD6);
    idle(40);
    async_reset();
    drive(0, 0, 0, 1, 0, 0);
    check("post_rst_err", 32'(err), 32'd1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        drive($urandom_range(0, 9) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
              $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
